// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
// State numbering FETCH=0 .. JUMP=9; codes 10-15 are unreachable.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control: sequences FETCH..WB per instruction,
// with memory-ready stalls and a retired-instruction counter.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rdy;
    logic             retire;

    assign rdy = mem_ready | ~USE_MEM_READY;

    always_comb begin
        state_d = FETCH;
        ill_d   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            FETCH:     state_d = rdy ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d = FETCH;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            MEM_ADDR:  state_d = (Op == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  state_d = rdy ? MEM_WB : MEM_READ;
            MEM_WRITE: begin
                state_d = rdy ? FETCH : MEM_WRITE;
                retire  = rdy;
            end
            EXECUTE:   state_d = R_WB;
            MEM_WB, R_WB, BRANCH, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default:   state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, retire};
        end
    end

    assign instr_count = cnt_q;
    assign illegal_op  = ill_q & rst_n;

    // Outputs held at zero during reset regardless of state.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_ADD;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUSRCB_B;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = ALUSRCB_FOUR;
                    IRWrite = rdy;
                    PCWrite = rdy;
                end
                DECODE:    ALUSrcB = ALUSRCB_IMM_SH;
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ALUSRCB_IMM;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors,
// stalls, illegal ops, mid-instruction reset and counter wrap.
module tb_multicycle_control;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,
    //  PCSource[1:0],ALUOp[1:0],ALUSrcA,ALUSrcB[1:0],RegWrite,RegDst}
    localparam logic [15:0] C_FETCH    = 16'h9204;
    localparam logic [15:0] C_FETCH_NR = 16'h1004;
    localparam logic [15:0] C_DECODE   = 16'h000C;
    localparam logic [15:0] C_MADDR    = 16'h0018;
    localparam logic [15:0] C_MREAD    = 16'h3000;
    localparam logic [15:0] C_MWB      = 16'h0402;
    localparam logic [15:0] C_MWRITE   = 16'h2800;
    localparam logic [15:0] C_EXEC     = 16'h0050;
    localparam logic [15:0] C_RWB      = 16'h0003;
    localparam logic [15:0] C_BRANCH   = 16'h40B0;
    localparam logic [15:0] C_JUMP     = 16'h8100;

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JJ  = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       mrdy;
    logic       chk_nr;
    int         checks = 0;
    int         failures = 0;

    logic a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_m2r, a_irw;
    logic a_srca, a_rw, a_rd, a_ill;
    logic [1:0] a_pcs, a_aluop, a_srcb;
    logic [31:0] a_cnt;

    logic c_pcw, c_pcwc, c_iord, c_mr, c_mw, c_m2r, c_irw;
    logic c_srca, c_rw, c_rd, c_ill;
    logic [1:0] c_pcs, c_aluop, c_srcb;
    logic [3:0] c_cnt;

    logic n_pcw, n_pcwc, n_iord, n_mr, n_mw, n_m2r, n_irw;
    logic n_srca, n_rw, n_rd, n_ill;
    logic [1:0] n_pcs, n_aluop, n_srcb;
    logic [31:0] n_cnt;

    wire [15:0] a_ctrl = {a_pcw, a_pcwc, a_iord, a_mr, a_mw, a_m2r, a_irw,
                          a_pcs, a_aluop, a_srca, a_srcb, a_rw, a_rd};
    wire [15:0] n_ctrl = {n_pcw, n_pcwc, n_iord, n_mr, n_mw, n_m2r, n_irw,
                          n_pcs, n_aluop, n_srca, n_srcb, n_rw, n_rd};

    always #5 clk = ~clk;

    multicycle_control u_main (
        .clk(clk), .rst_n(rst_n), .Op(op), .mem_ready(mrdy),
        .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord),
        .MemRead(a_mr), .MemWrite(a_mw), .MemtoReg(a_m2r),
        .IRWrite(a_irw), .PCSource(a_pcs), .ALUOp(a_aluop),
        .ALUSrcA(a_srca), .ALUSrcB(a_srcb), .RegWrite(a_rw),
        .RegDst(a_rd), .illegal_op(a_ill), .instr_count(a_cnt)
    );

    multicycle_control #(.CNT_W(4)) u_cnt4 (
        .clk(clk), .rst_n(rst_n), .Op(op), .mem_ready(mrdy),
        .PCWrite(c_pcw), .PCWriteCond(c_pcwc), .IorD(c_iord),
        .MemRead(c_mr), .MemWrite(c_mw), .MemtoReg(c_m2r),
        .IRWrite(c_irw), .PCSource(c_pcs), .ALUOp(c_aluop),
        .ALUSrcA(c_srca), .ALUSrcB(c_srcb), .RegWrite(c_rw),
        .RegDst(c_rd), .illegal_op(c_ill), .instr_count(c_cnt)
    );

    multicycle_control #(.USE_MEM_READY(1'b0)) u_nordy (
        .clk(clk), .rst_n(rst_n), .Op(op), .mem_ready(1'b0),
        .PCWrite(n_pcw), .PCWriteCond(n_pcwc), .IorD(n_iord),
        .MemRead(n_mr), .MemWrite(n_mw), .MemtoReg(n_m2r),
        .IRWrite(n_irw), .PCSource(n_pcs), .ALUOp(n_aluop),
        .ALUSrcA(n_srca), .ALUSrcB(n_srcb), .RegWrite(n_rw),
        .RegDst(n_rd), .illegal_op(n_ill), .instr_count(n_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; checks the current state mid-cycle.
    task automatic cyc(input string tag, input logic [5:0] o,
                       input logic r, input logic [15:0] exp,
                       input logic ill);
        op   = o;
        mrdy = r;
        @(negedge clk);
        check(tag, {16'h0, a_ctrl}, {16'h0, exp});
        check({tag, "_ill"}, {31'h0, a_ill}, {31'h0, ill});
        if (chk_nr) check({tag, "_nr"}, {16'h0, n_ctrl}, {16'h0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        op     = 6'bxxxxxx;
        mrdy   = 1'b0;
        chk_nr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {16'h0, a_ctrl}, 32'h0);
        check("rst_ill", {31'h0, a_ill}, 32'h0);
        check("rst_cnt", a_cnt, 32'h0);
        check("rst_ctrl_nr", {16'h0, n_ctrl}, 32'h0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_nr = 1'b1;

        // lw, 5 cycles; also on the instance that ignores mem_ready
        cyc("lw_fetch", LW, 1'b1, C_FETCH, 1'b0);
        cyc("lw_dec", LW, 1'b1, C_DECODE, 1'b0);
        cyc("lw_addr", LW, 1'b1, C_MADDR, 1'b0);
        cyc("lw_read", LW, 1'b1, C_MREAD, 1'b0);
        cyc("lw_wb", LW, 1'b1, C_MWB, 1'b0);
        check("lw_cnt", a_cnt, 32'd1);
        check("lw_cnt_nr", n_cnt, 32'd1);
        chk_nr = 1'b0;

        // sw with a 3-cycle memory stall
        cyc("sw_fetch", SW, 1'b1, C_FETCH, 1'b0);
        cyc("sw_dec", SW, 1'b1, C_DECODE, 1'b0);
        cyc("sw_addr", SW, 1'b1, C_MADDR, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc($sformatf("sw_wait%0d", i), SW, 1'b0, C_MWRITE, 1'b0);
        check("sw_cnt_stall", a_cnt, 32'd1);
        cyc("sw_done", SW, 1'b1, C_MWRITE, 1'b0);
        check("sw_cnt", a_cnt, 32'd2);

        // R-type with a fetch stall; Op changes after decode are ignored
        cyc("r_fetch_wait", RT, 1'b0, C_FETCH_NR, 1'b0);
        cyc("r_fetch", RT, 1'b1, C_FETCH, 1'b0);
        cyc("r_dec", RT, 1'b1, C_DECODE, 1'b0);
        cyc("r_exec", LW, 1'b1, C_EXEC, 1'b0);
        cyc("r_wb", BAD, 1'b1, C_RWB, 1'b0);
        cyc("beq_fetch", BEQ, 1'b1, C_FETCH, 1'b0);
        cyc("beq_dec", BEQ, 1'b1, C_DECODE, 1'b0);
        cyc("beq_br", BEQ, 1'b1, C_BRANCH, 1'b0);
        cyc("j_fetch", JJ, 1'b1, C_FETCH, 1'b0);
        cyc("j_dec", JJ, 1'b1, C_DECODE, 1'b0);
        cyc("j_jump", RT, 1'b1, C_JUMP, 1'b0);
        check("rbj_cnt", a_cnt, 32'd5);

        // illegal opcode: 1-cycle pulse, no retire
        cyc("ill_fetch", BAD, 1'b1, C_FETCH, 1'b0);
        cyc("ill_dec", BAD, 1'b1, C_DECODE, 1'b0);
        cyc("ill_pulse", LW, 1'b0, C_FETCH_NR, 1'b1);
        cyc("ill_clr", LW, 1'b0, C_FETCH_NR, 1'b0);
        check("ill_cnt", a_cnt, 32'd5);

        // reset while stalled in MEM_READ
        cyc("mr_fetch", LW, 1'b1, C_FETCH, 1'b0);
        cyc("mr_dec", LW, 1'b1, C_DECODE, 1'b0);
        cyc("mr_addr", LW, 1'b1, C_MADDR, 1'b0);
        cyc("mr_read", LW, 1'b0, C_MREAD, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mr_rst_ctrl", {16'h0, a_ctrl}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mr_rst_cnt", a_cnt, 32'h0);
        check("mr_rst_cnt4", {28'h0, c_cnt}, 32'h0);

        // 16 jumps: 4-bit counter wraps to zero
        for (int i = 0; i < 16; i++) begin
            cyc($sformatf("wr_f%0d", i), JJ, 1'b1, C_FETCH, 1'b0);
            cyc($sformatf("wr_d%0d", i), JJ, 1'b1, C_DECODE, 1'b0);
            cyc($sformatf("wr_j%0d", i), JJ, 1'b1, C_JUMP, 1'b0);
            if (i == 14) check("wr_cnt4_15", {28'h0, c_cnt}, 32'd15);
        end
        check("wr_cnt4_wrap", {28'h0, c_cnt}, 32'h0);
        check("wr_cnt32", a_cnt, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
